// File: rtl/mmio_io_ctrl_if.sv
// CPU data-port bundle for the MMIO I/O controller.
// The master is the CPU side and the slave is the controller.
interface mmio_io_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped GPIO register block: LED, switches, sticky button events, seven-segment data,
// control bits and a cycle counter, served one request at a time over a valid/ready port.
module mmio_io_ctrl #(
  parameter logic [31:0] ADDR_BASE = 32'hFFFF_FF00,
  parameter int unsigned BTN_N     = 5
) (
  input  logic             clk,
  input  logic             reset,
  mmio_io_ctrl_if.slave    bus,
  input  logic [15:0]      i_switch,
  input  logic [BTN_N-1:0] i_btn_down,
  output logic [15:0]      o_led,
  output logic [31:0]      o_seg_data,
  output logic             o_seg_sel,
  output logic             o_irq
);

  localparam logic [7:0] OFF_LED   = 8'h00;
  localparam logic [7:0] OFF_SW    = 8'h04;
  localparam logic [7:0] OFF_BTN   = 8'h08;
  localparam logic [7:0] OFF_SEG   = 8'h0C;
  localparam logic [7:0] OFF_CTRL  = 8'h10;
  localparam logic [7:0] OFF_CYCLE = 8'h14;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  logic             r_req_ready;
  logic             r_resp_valid;
  logic             r_resp_err;
  logic [31:0]      r_resp_rdata;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  logic [15:0]      r_led;
  logic [15:0]      r_sw_meta;
  logic [15:0]      r_sw_sync;
  logic [31:0]      r_seg;
  logic             r_seg_sel;
  logic             r_irq_en;
  logic             r_irq;
  logic [31:0]      r_cycle;
  logic [BTN_N-1:0] r_evt;

  logic             w_err;
  logic [31:0]      w_rdata;
  logic             w_exec;
  logic             w_wr_ok;
  logic [BTN_N-1:0] w_evt_clr;

  // Decode the latched request; stores and errors always return zero data.
  always_comb begin
    w_err   = 1'b0;
    w_rdata = '0;
    if (r_addr[31:8] != ADDR_BASE[31:8] || r_addr[1:0] != 2'b00) begin
      w_err = 1'b1;
    end else begin
      case (r_addr[7:0])
        OFF_LED:   w_rdata = {16'h0000, r_led};
        OFF_SW:    begin w_rdata = {16'h0000, r_sw_sync}; w_err = r_we; end
        OFF_BTN:   begin w_rdata = 32'(r_evt); w_err = r_we; end
        OFF_SEG:   w_rdata = r_seg;
        OFF_CTRL:  w_rdata = {30'h0, r_irq_en, r_seg_sel};
        OFF_CYCLE: begin w_rdata = r_cycle; w_err = r_we; end
        default:   w_err = 1'b1;
      endcase
    end
    if (w_err || r_we) begin
      w_rdata = '0;
    end
  end

  assign w_exec    = (r_state == EXEC);
  assign w_wr_ok   = w_exec && r_we && !w_err;
  assign w_evt_clr = (w_exec && !r_we && !w_err && r_addr[7:0] == OFF_BTN) ? r_evt : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_req_ready <= 1'b0;
            r_state     <= EXEC;
          end
        end
        EXEC: begin
          r_resp_rdata <= w_rdata;
          r_resp_err   <= w_err;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  // A press arriving in the same cycle as a clearing read survives, since only the returned bits clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led     <= '0;
      r_seg     <= '0;
      r_seg_sel <= 1'b0;
      r_irq_en  <= 1'b0;
      r_irq     <= 1'b0;
      r_cycle   <= '0;
      r_evt     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= i_switch;
      r_sw_sync <= r_sw_meta;
      r_cycle   <= r_cycle + 32'd1;
      r_evt     <= (r_evt & ~w_evt_clr) | i_btn_down;
      r_irq     <= r_irq_en & (|r_evt);
      if (w_wr_ok) begin
        case (r_addr[7:0])
          OFF_LED:  r_led <= r_wdata[15:0];
          OFF_SEG:  r_seg <= r_wdata;
          OFF_CTRL: begin
            r_seg_sel <= r_wdata[0];
            r_irq_en  <= r_wdata[1];
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign o_led          = r_led;
  assign o_seg_data     = r_seg;
  assign o_seg_sel      = r_seg_sel;
  assign o_irq          = r_irq;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl: each step drives the bus one cycle at a time and
// compares outputs against hand-computed values.
module tb_mmio_io_ctrl;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] i_switch;
  logic [4:0]  i_btn_down;
  logic [15:0] o_led;
  logic [31:0] o_seg_data;
  logic        o_seg_sel;
  logic        o_irq;

  int errors = 0;
  int checks = 0;

  mmio_io_ctrl_if bus();

  mmio_io_ctrl #(.ADDR_BASE(BASE), .BTN_N(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .i_switch   (i_switch),
    .i_btn_down (i_btn_down),
    .o_led      (o_led),
    .o_seg_data (o_seg_data),
    .o_seg_sel  (o_seg_sel),
    .o_irq      (o_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; execPulse is driven on btn_down during the EXEC cycle.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] execPulse,
                               output logic [31:0] rd, output logic er, output int lat);
    int waitCnt;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    waitCnt = 0;
    while (!bus.req_ready && waitCnt < 50) begin
      tick();
      waitCnt++;
    end
    checkOutput("accept", {31'h0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    i_btn_down    = execPulse;
    tick();
    i_btn_down = '0;
    lat = 2;
    while (!bus.resp_valid && lat < 50) begin
      tick();
      lat++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] c1;
    logic [31:0] c2;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    i_switch       = '0;
    i_btn_down     = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rstReqReady", {31'h0, bus.req_ready}, 32'd1);
    checkOutput("rstRespValid", {31'h0, bus.resp_valid}, 32'd0);
    checkOutput("rstRdata", bus.resp_rdata, 32'd0);
    checkOutput("rstErr", {31'h0, bus.resp_err}, 32'd0);
    checkOutput("rstLed", {16'h0, o_led}, 32'd0);
    checkOutput("rstSeg", o_seg_data, 32'd0);
    checkOutput("rstSegSel", {31'h0, o_seg_sel}, 32'd0);
    checkOutput("rstIrq", {31'h0, o_irq}, 32'd0);
    applyStimulus(1'b0, BASE + 32'h14, 32'h0, 5'b0, rd, er, lat);
    checkOutput("cycleAfterRst", rd, 32'd2);

    $display("[TB] LED store and load");
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = BASE;
    bus.req_wdata = 32'h0000_A5A5;
    checkOutput("ledAccept", {31'h0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    checkOutput("ledN1", {16'h0, o_led}, 32'd0);
    checkOutput("ledN1Valid", {31'h0, bus.resp_valid}, 32'd0);
    tick();
    checkOutput("ledN2", {16'h0, o_led}, 32'h0000_A5A5);
    checkOutput("ledN2Valid", {31'h0, bus.resp_valid}, 32'd1);
    checkOutput("ledStoreErr", {31'h0, bus.resp_err}, 32'd0);
    checkOutput("ledStoreRdata", bus.resp_rdata, 32'd0);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    checkOutput("ledM1Ready", {31'h0, bus.req_ready}, 32'd1);
    checkOutput("ledM1Valid", {31'h0, bus.resp_valid}, 32'd0);
    applyStimulus(1'b0, BASE, 32'h0, 5'b0, rd, er, lat);
    checkOutput("ledLoad", rd, 32'h0000_A5A5);
    checkOutput("ledLoadErr", {31'h0, er}, 32'd0);
    checkOutput("ledLoadLat", 32'(lat), 32'd2);
    applyStimulus(1'b1, BASE, 32'hFFFF_1234, 5'b0, rd, er, lat);
    applyStimulus(1'b0, BASE, 32'h0, 5'b0, rd, er, lat);
    checkOutput("ledUpperZero", rd, 32'h0000_1234);
    checkOutput("ledPins", {16'h0, o_led}, 32'h0000_1234);

    $display("[TB] switch read");
    i_switch = 16'hBEEF;
    repeat (3) tick();
    applyStimulus(1'b0, BASE + 32'h04, 32'h0, 5'b0, rd, er, lat);
    checkOutput("swLoad", rd, 32'h0000_BEEF);

    $display("[TB] button events");
    i_btn_down = 5'b00101;
    tick();
    i_btn_down = 5'b0;
    applyStimulus(1'b0, BASE + 32'h08, 32'h0, 5'b00010, rd, er, lat);
    checkOutput("btnFirst", rd, 32'h5);
    applyStimulus(1'b0, BASE + 32'h08, 32'h0, 5'b0, rd, er, lat);
    checkOutput("btnSecond", rd, 32'h2);
    applyStimulus(1'b0, BASE + 32'h08, 32'h0, 5'b0, rd, er, lat);
    checkOutput("btnThird", rd, 32'h0);

    $display("[TB] control and irq");
    applyStimulus(1'b1, BASE + 32'h10, 32'h3, 5'b0, rd, er, lat);
    checkOutput("segSelOn", {31'h0, o_seg_sel}, 32'd1);
    i_btn_down = 5'b10000;
    tick();
    i_btn_down = 5'b0;
    checkOutput("irqDelay", {31'h0, o_irq}, 32'd0);
    tick();
    checkOutput("irqHigh", {31'h0, o_irq}, 32'd1);
    applyStimulus(1'b0, BASE + 32'h08, 32'h0, 5'b0, rd, er, lat);
    checkOutput("btnIrqEvt", rd, 32'h10);
    checkOutput("irqCleared", {31'h0, o_irq}, 32'd0);
    applyStimulus(1'b1, BASE + 32'h10, 32'h1, 5'b0, rd, er, lat);
    i_btn_down = 5'b00001;
    tick();
    i_btn_down = 5'b0;
    repeat (2) tick();
    checkOutput("irqMasked", {31'h0, o_irq}, 32'd0);
    checkOutput("segSelStill", {31'h0, o_seg_sel}, 32'd1);
    applyStimulus(1'b0, BASE + 32'h10, 32'h0, 5'b0, rd, er, lat);
    checkOutput("ctrlLoad", rd, 32'h1);
    applyStimulus(1'b0, BASE + 32'h08, 32'h0, 5'b0, rd, er, lat);
    checkOutput("btnMaskedEvt", rd, 32'h1);

    $display("[TB] error accesses");
    applyStimulus(1'b0, BASE + 32'h14, 32'h0, 5'b0, c1, er, lat);
    applyStimulus(1'b0, BASE + 32'h18, 32'h0, 5'b0, rd, er, lat);
    checkOutput("errOffErr", {31'h0, er}, 32'd1);
    checkOutput("errOffData", rd, 32'd0);
    applyStimulus(1'b0, BASE + 32'h02, 32'h0, 5'b0, rd, er, lat);
    checkOutput("errAlignErr", {31'h0, er}, 32'd1);
    checkOutput("errAlignData", rd, 32'd0);
    applyStimulus(1'b1, BASE + 32'h14, 32'h55, 5'b0, rd, er, lat);
    checkOutput("errRoErr", {31'h0, er}, 32'd1);
    checkOutput("errRoData", rd, 32'd0);
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, 5'b0, rd, er, lat);
    checkOutput("errBaseErr", {31'h0, er}, 32'd1);
    applyStimulus(1'b0, BASE + 32'h14, 32'h0, 5'b0, c2, er, lat);
    checkOutput("cycleDelta", c2 - c1, 32'd15);
    applyStimulus(1'b1, BASE + 32'h0C, 32'h1234_5678, 5'b0, rd, er, lat);
    checkOutput("legalAfterErr", {31'h0, er}, 32'd0);
    checkOutput("segPins", o_seg_data, 32'h1234_5678);
    i_btn_down = 5'b01000;
    tick();
    i_btn_down = 5'b0;
    tick();
    applyStimulus(1'b0, BASE + 32'h0A, 32'h0, 5'b0, rd, er, lat);
    checkOutput("btnMisalignErr", {31'h0, er}, 32'd1);
    applyStimulus(1'b0, BASE + 32'h08, 32'h0, 5'b0, rd, er, lat);
    checkOutput("btnNotCleared", rd, 32'h8);

    $display("[TB] back-pressure");
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = BASE + 32'h0C;
    tick();
    bus.req_valid = 1'b0;
    tick();
    checkOutput("bpValid", {31'h0, bus.resp_valid}, 32'd1);
    checkOutput("bpData", bus.resp_rdata, 32'h1234_5678);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = BASE;
    bus.req_wdata = 32'h0000_0F0F;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bpHoldValid", {31'h0, bus.resp_valid}, 32'd1);
      checkOutput("bpHoldData", bus.resp_rdata, 32'h1234_5678);
      checkOutput("bpHoldReady", {31'h0, bus.req_ready}, 32'd0);
      checkOutput("bpHoldLed", {16'h0, o_led}, 32'h0000_1234);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    checkOutput("bpReadyAfter", {31'h0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    checkOutput("bpLedNotYet", {16'h0, o_led}, 32'h0000_1234);
    tick();
    checkOutput("bpSecondLed", {16'h0, o_led}, 32'h0000_0F0F);
    checkOutput("bpSecondValid", {31'h0, bus.resp_valid}, 32'd1);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;

    $display("[TB] reset during EXEC");
    i_btn_down = 5'b00100;
    tick();
    i_btn_down = 5'b0;
    tick();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = BASE;
    bus.req_wdata = 32'h0000_3C3C;
    tick();
    bus.req_valid = 1'b0;
    reset      = 1'b1;
    i_btn_down = 5'b11111;
    tick();
    reset      = 1'b0;
    i_btn_down = 5'b0;
    checkOutput("midRstLed", {16'h0, o_led}, 32'd0);
    checkOutput("midRstValid", {31'h0, bus.resp_valid}, 32'd0);
    checkOutput("midRstReady", {31'h0, bus.req_ready}, 32'd1);
    checkOutput("midRstSegSel", {31'h0, o_seg_sel}, 32'd0);
    checkOutput("midRstSeg", o_seg_data, 32'd0);
    tick();
    checkOutput("midRstLedLater", {16'h0, o_led}, 32'd0);
    applyStimulus(1'b0, BASE + 32'h08, 32'h0, 5'b0, rd, er, lat);
    checkOutput("midRstEvt", rd, 32'h0);
    checkOutput("midRstEvtErr", {31'h0, er}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
